count_capture_fifo: RTL
=======================

COUNT_CAPTURE_FIFO -- requirements
Module: count_capture_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 8: width of the captured count value.
REQ-002 SHALL have parameter DEPTH, default 4: number of FIFO entries; a power of 2, at least 2.
REQ-003 SHALL have port clk  input  1: clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1: reset, asynchronous, active-high.
REQ-005 SHALL have port count  input  WIDTH: live counter value being sampled.
REQ-006 SHALL have port overflow  input  1: counter overflow flag, level.
REQ-007 SHALL have port capture  input  1: manual snapshot request, sampled every cycle.
REQ-008 SHALL have port out_ready  input  1: consumer accepts the head entry.
REQ-009 SHALL have port out_valid  output  1: head entry present.
REQ-010 SHALL have port out_data  output  WIDTH+2: head entry as {cap_tag, ovf_tag, count}.
REQ-011 SHALL have port level  output  clog2(DEPTH)+1: number of entries currently stored.
REQ-012 SHALL have port full  output  1: level == DEPTH.
REQ-013 SHALL have port empty  output  1: level == 0.
REQ-014 SHALL have port drop_cnt  output  8: saturating count of events lost because the FIFO was full.

Function
REQ-015 SHALL register overflow each cycle into ovf_q; ovf_rise = overflow & ~ovf_q.
REQ-016 SHALL define an event in any cycle where capture | ovf_rise is true.
REQ-017 SHALL form each pushed entry from that same cycle's inputs: {capture, ovf_rise, count}.
REQ-018 SHALL merge a simultaneous capture and ovf_rise into one entry with both tags set.
REQ-019 SHALL be first-word-fall-through: out_data always shows the oldest entry; out_data is don't-care when out_valid = 0.
REQ-020 SHALL have push-to-visible latency of 1: an event at edge N gives out_valid = 1 after edge N when the FIFO was empty.
REQ-021 SHALL pop on any edge where out_valid & out_ready is true; out_ready is ignored when out_valid = 0.
REQ-022 SHALL accept the push when full and a pop occurs in the same cycle; level stays DEPTH.
REQ-023 SHALL do both operations when a push and pop occur together at any level below full; level is unchanged.
REQ-024 SHALL drop an event that arrives when full with no pop; drop_cnt increments by 1 and the stored contents are unchanged.
REQ-025 SHALL saturate drop_cnt at 255; it does not wrap.
REQ-026 SHALL wrap read and write pointers modulo DEPTH; level distinguishes full from empty.
REQ-027 SHALL derive out_valid, full, empty and level from registered state only, with no combinational path from inputs.
REQ-028 SHALL produce no second event while overflow stays high; a new event requires overflow to fall and rise again.

Reset
REQ-029 SHALL, while reset is high, asynchronously set out_valid=0, empty=1, full=0, level=0, drop_cnt=0, ovf_q=0, and both pointers to 0.
REQ-030 SHALL discard all stored entries when reset is asserted mid-operation; no entry survives reset.
REQ-031 SHALL treat overflow = 1 in the first cycle after reset release as a rising edge, because ovf_q = 0.

Configuration
REQ-032 SHALL implement drop_cnt and its counter only when macro COUNT_CAPTURE_DROP_CNT_EN is defined.
REQ-033 SHALL, without COUNT_CAPTURE_DROP_CNT_EN, tie drop_cnt to 0 and keep all other behaviour identical, including silently dropping events when full.

Verification (WIDTH=8, DEPTH=4)
REQ-034 SHALL cover single capture: count=0x2A, capture pulsed 1 cycle -> next cycle out_valid=1, out_data=0x22A, level=1.
REQ-035 SHALL cover overflow edge: overflow held high 3 cycles with count=0x00 -> exactly one entry 0x100; level=1.
REQ-036 SHALL cover overflow/capture merge: capture and overflow rise together, count=0xFF -> one entry 0x3FF.
REQ-037 SHALL cover fill and drop: 6 captures with out_ready=0, count=1..6 -> full=1, level=4, drop_cnt=2; then drain with out_ready=1 -> order 0x201,0x202,0x203,0x204, then empty=1.
REQ-038 SHALL cover push+pop when full: full FIFO, out_ready=1 and capture with count=0x77 in the same cycle -> level stays 4, drop_cnt unchanged, 0x277 is the last entry drained.
REQ-039 SHALL cover reset mid-operation: level=3, assert reset -> out_valid=0, level=0, drop_cnt=0 immediately, before the next clk edge.

Source files
------------

// File: rtl/count_capture_fifo.sv
// count_capture_fifo
//   Captures the live counter value into a small first-word-fall-through FIFO
//   whenever a manual capture is requested or the counter overflow flag rises.
//   Each entry is {cap_tag, ovf_tag, count}. Events arriving while the FIFO
//   is full (and no pop frees a slot) are dropped.
//
//   Optional feature: define COUNT_CAPTURE_DROP_CNT_EN to build the saturating
//   drop counter; without it drop_cnt is tied to 0.
//
// Ports
//   clk        : clock, rising edge
//   reset      : asynchronous, active-high reset
//   count      : live counter value (WIDTH bits)
//   overflow   : counter overflow flag (level)
//   capture    : manual snapshot request
//   out_ready  : consumer accepts the head entry
//   out_valid  : head entry present
//   out_data   : head entry {cap_tag, ovf_tag, count}
//   level      : number of stored entries
//   full       : level == DEPTH
//   empty      : level == 0
//   drop_cnt   : saturating count of events lost while full
module count_capture_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         count,
  input  logic                     overflow,
  input  logic                     capture,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [WIDTH+1:0]         out_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty,
  output logic [7:0]               drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  logic [WIDTH+1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      level_q;
  logic             ovf_q;

  logic ovf_rise;
  logic evt;
  logic pop;
  logic push;

  assign ovf_rise = overflow & ~ovf_q;
  assign evt      = capture | ovf_rise;

  // Status comes purely from the registered level.
  assign level     = level_q;
  assign out_valid = (level_q != '0);
  assign empty     = (level_q == '0);
  assign full      = (level_q == LVL_FULL);
  assign out_data  = mem[rd_ptr];

  assign pop  = out_valid & out_ready;
  // A pop in the same cycle frees the slot a full FIFO needs for the push.
  assign push = evt & (~full | pop);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {capture, ovf_rise, count};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      ovf_q <= overflow;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

`ifdef COUNT_CAPTURE_DROP_CNT_EN
  logic       drop;
  logic [7:0] drop_q;

  assign drop     = evt & full & ~pop;
  assign drop_cnt = drop_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_q <= '0;
    end else if (drop && (drop_q != '1)) begin
      drop_q <= drop_q + 8'd1;
    end
  end
`else
  assign drop_cnt = '0;
`endif

endmodule
